// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio playback path.
// Used by the ROM fetch stage, the PWM output stage and their testbenches.
//   sample_div()    : system clocks per PCM sample (floor)
//   midscale()      : duty value for silence at a given PWM resolution
//   pcm_to_offset() : signed PCM -> offset-binary duty, top 'bits' bits kept
package audio_pkg;

  localparam int unsigned CLK_HZ_DEFAULT    = 100_000_000;
  localparam int unsigned SAMPLE_HZ_DEFAULT = 44_100;
  localparam int unsigned PWM_BITS_DEFAULT  = 8;

  function automatic int unsigned sample_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  function automatic int unsigned midscale(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  localparam int unsigned SAMPLE_DIV_DEFAULT = sample_div(CLK_HZ_DEFAULT, SAMPLE_HZ_DEFAULT);
  localparam int unsigned MIDSCALE           = midscale(PWM_BITS_DEFAULT);

  // Flipping the sign bit maps -32768..32767 onto 0..65535; the shift keeps
  // the most significant 'bits' bits as the duty value.
  function automatic logic [15:0] pcm_to_offset(input logic [15:0] sample,
                                                input int unsigned bits);
    return (sample ^ 16'h8000) >> (16 - bits);
  endfunction

endpackage

// File: rtl/pwm_carrier.sv
// PWM carrier: free-running counter of 2**PWM_BITS clocks, duty register that
// only reloads at the counter wrap, and a registered compare output.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   en_i   : low holds counter at 0, duty at mid-scale, output low
//   duty_i : requested duty (sampled at carrier boundary only)
//   pwm_o  : registered PWM output
module pwm_carrier
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    pwm_d  = pwm_q;
    if (!en_i) begin
      cnt_d  = '0;
      duty_d = MID;
      pwm_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      // Loading only on the last count keeps every period whole.
      if (cnt_q == '1) duty_d = duty_i;
      pwm_d = (cnt_q < duty_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= MID;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pcm_pwm_modulator.sv
// PCM -> PWM output stage. Accepts signed 16-bit samples over valid/ready,
// consumes one per sample tick, and drives the mono amp pins.
//   Clock_100MHz   : system clock
//   Clear          : synchronous active-high reset (overrides Enable)
//   Enable         : playback enable; low shuts the amp down and flushes
//   Sample_Data/Valid/Ready : one-deep holding register handshake
//   Underrun_Clr   : pulse clears Underrun and Underrun_Count
//   Underrun       : sticky, a tick found no pending sample
//   Underrun_Count : saturating count of underrun ticks
//   AUD_PWM/AUD_SD : registered amp PWM and enable
module pcm_pwm_modulator
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int unsigned SAMPLE_HZ = SAMPLE_HZ_DEFAULT,
  parameter int unsigned PWM_BITS  = PWM_BITS_DEFAULT
) (
  input  logic        Clock_100MHz,
  input  logic        Clear,
  input  logic        Enable,
  input  logic [15:0] Sample_Data,
  input  logic        Sample_Valid,
  output logic        Sample_Ready,
  input  logic        Underrun_Clr,
  output logic        Underrun,
  output logic [15:0] Underrun_Count,
  output logic        AUD_PWM,
  output logic        AUD_SD
);

  localparam int unsigned SAMPLE_DIV = sample_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0]       TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MID       = PWM_BITS'(midscale(PWM_BITS));

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [15:0]         pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         ucnt_q, ucnt_d;
  logic                sd_q;
  logic                tick;
  logic                accept;

  assign Sample_Ready = !Clear && Enable && !pend_vld_q;
  assign accept       = Sample_Valid && Sample_Ready;
  assign tick         = Enable && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    shadow_d   = shadow_q;
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;

    // Clear first so that an underrun in the same cycle overrides it.
    if (Underrun_Clr) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
    end

    if (!Enable) begin
      tick_cnt_d = '0;
      pend_vld_d = 1'b0;
      shadow_d   = MID;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        if (pend_vld_q) begin
          shadow_d   = PWM_BITS'(pcm_to_offset(pend_q, PWM_BITS));
          pend_vld_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
          if (ucnt_d != '1) ucnt_d = ucnt_d + 1'b1;
        end
      end
      // Accept only happens with pending empty, so a same-cycle tick has
      // already scored the underrun; the word waits for the next tick.
      if (accept) begin
        pend_d     = Sample_Data;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      tick_cnt_q <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= MID;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
      sd_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      shadow_q   <= shadow_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
      sd_q       <= Enable;
    end
  end

  pwm_carrier #(
    .PWM_BITS(PWM_BITS)
  ) u_carrier (
    .clk_i (Clock_100MHz),
    .rst_i (Clear),
    .en_i  (Enable),
    .duty_i(shadow_q),
    .pwm_o (AUD_PWM)
  );

  assign Underrun       = underrun_q;
  assign Underrun_Count = ucnt_q;
  assign AUD_SD         = sd_q;

endmodule
